// File: rtl/nios_system_pushbutton_ctrl.sv
// Avalon-MM pushbutton peripheral: 2-flop sync, per-button debounce, W1C press capture, maskable IRQ.
// Define PB_CTRL_DEBOUNCE_EN to build the debounce counters; otherwise stable follows sync each clock.
module nios_system_pushbutton_ctrl #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DB_CYCLES = 50000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic             gie_q, gie_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    if (DB_CYCLES < 2 || (longint'(DB_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_cfg_check
        $error("DB_CYCLES must be >= 2 and DB_CYCLES-1 must fit in CNT_W bits");
    end

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata[31:WIDTH];

`ifdef PB_CTRL_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Counter runs only while sync disagrees with stable; any agreement restarts it.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    always_comb begin
        stable_d = sync2_q;
    end
`endif

    always_comb begin
        mask_d = mask_q;
        gie_d  = gie_q;
        edge_d = edge_q;
        if (wr_en) begin
            case (address)
                2'd1:    mask_d = writedata[WIDTH-1:0];
                2'd2:    edge_d = edge_q & ~writedata[WIDTH-1:0];
                2'd3:    gie_d  = writedata[0];
                default: ;
            endcase
        end
        // A press landing on the same edge as a clear wins.
        edge_d = edge_d | (stable_q & ~stable_d);

        case (address)
            2'd0:    readdata_d = 32'(stable_q);
            2'd1:    readdata_d = 32'(mask_q);
            2'd2:    readdata_d = 32'(edge_q);
            default: readdata_d = {31'b0, gie_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            stable_q   <= '1;
            mask_q     <= '0;
            edge_q     <= '0;
            gie_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            gie_q      <= gie_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = gie_q & |(edge_q & mask_q);

endmodule
